riio_supply_seq: RTL and testbench

- Parametrised IO-ring supply sequencer; successor to the single passive VDDIOX supply pad.
- Drives the enable of N_DOM switchable IO supply domains (VDDIOX/VDDIO-class rails), each fed back by a power-good flag.
- Powers up in index order and down in reverse order, with per-step timeout and settle timing.
- Sits in the always-on core domain beside the pad ring and is controlled by the PMU.

---
 rtl/riio_supply_seq_pkg.sv | 28 ++
 rtl/riio_sync2.sv | 24 ++
 rtl/riio_supply_seq.sv | 185 ++++++++++++++++++
 tb/tb_riio_supply_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riio_supply_seq_pkg.sv
// Shared types and sizing helpers for the IO-ring supply sequencer.
package riio_supply_seq_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_UP_WAIT,
        S_UP_SETTLE,
        S_ON,
        S_DN_WAIT,
        S_DN_SETTLE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE       = 2'b00,
        FC_UP_TIMEOUT = 2'b01,
        FC_DN_TIMEOUT = 2'b10,
        FC_PG_LOSS    = 2'b11
    } fault_code_t;

    // One counter serves both timeout and settle, so size it for the larger.
    function automatic int cnt_width(input int timeout_cyc, input int settle_cyc);
        int max_cyc;
        max_cyc = (timeout_cyc > settle_cyc) ? timeout_cyc : settle_cyc;
        return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/riio_sync2.sv
// N-bit two-flop synchroniser for asynchronous status inputs; resets to 0.
module riio_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking keeps meta and q as two distinct stages; blocking would collapse them into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/riio_supply_seq.sv
// IO-ring supply sequencer: enables domains in index order on power-up and
// reverse order on power-down, with per-step pg timeout and settle delay.
module riio_supply_seq
    import riio_supply_seq_pkg::*;
#(
    parameter int N_DOM       = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int SETTLE_CYC  = 64,
    parameter int DOM_W       = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_req_i,
    input  logic             dn_req_i,
    input  logic             clr_fault_i,
    input  logic [N_DOM-1:0] pg_i,
    output logic [N_DOM-1:0] en_o,
    output logic             all_on_o,
    output logic             busy_o,
    output logic             fault_o,
    output logic [DOM_W-1:0] fault_dom_o,
    output logic [1:0]       fault_code_o
);

    localparam int               CNT_W     = cnt_width(TIMEOUT_CYC, SETTLE_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_CYC);
    localparam logic [DOM_W-1:0] LAST_IDX  = DOM_W'(N_DOM - 1);

    state_t           state;
    logic [DOM_W-1:0] idx;
    logic [DOM_W-1:0] idx_nxt;
    logic [DOM_W-1:0] idx_prv;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [N_DOM-1:0] pg_s;
    logic             pg_idx;
    logic [DOM_W-1:0] loss_dom;

    riio_sync2 #(.WIDTH(N_DOM)) u_pg_sync (
        .clk (clk),
        .rst (rst),
        .d   (pg_i),
        .q   (pg_s)
    );

    // Saturating increment; the priority scan yields the lowest domain with pg low.
    always_comb begin
        cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        idx_nxt  = idx + DOM_W'(1);
        idx_prv  = idx - DOM_W'(1);
        pg_idx   = pg_s[idx];
        loss_dom = '0;
        for (int i = N_DOM - 1; i >= 0; i--) begin
            if (!pg_s[i]) loss_dom = DOM_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_OFF;
            idx          <= '0;
            cnt          <= '0;
            en_o         <= '0;
            all_on_o     <= 1'b0;
            busy_o       <= 1'b0;
            fault_o      <= 1'b0;
            fault_dom_o  <= '0;
            fault_code_o <= FC_NONE;
        end else begin
            case (state)
                S_OFF: begin
                    if (up_req_i && !dn_req_i) begin
                        state   <= S_UP_WAIT;
                        idx     <= '0;
                        cnt     <= '0;
                        en_o[0] <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end

                S_UP_WAIT, S_UP_SETTLE: begin
                    if (dn_req_i) begin
                        // Abort: unwind from the domain currently in progress.
                        state     <= S_DN_WAIT;
                        cnt       <= '0;
                        en_o[idx] <= 1'b0;
                    end else if (state == S_UP_WAIT) begin
                        if (pg_idx) begin
                            state <= S_UP_SETTLE;
                            cnt   <= '0;
                        end else if (cnt >= TIMEOUT_C) begin
                            state        <= S_FAULT;
                            en_o         <= '0;
                            busy_o       <= 1'b0;
                            fault_o      <= 1'b1;
                            fault_dom_o  <= idx;
                            fault_code_o <= FC_UP_TIMEOUT;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else if (cnt >= SETTLE_C) begin
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state    <= S_ON;
                            busy_o   <= 1'b0;
                            all_on_o <= 1'b1;
                        end else begin
                            state         <= S_UP_WAIT;
                            idx           <= idx_nxt;
                            en_o[idx_nxt] <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_ON: begin
                    if (!(&pg_s)) begin
                        state        <= S_FAULT;
                        en_o         <= '0;
                        all_on_o     <= 1'b0;
                        fault_o      <= 1'b1;
                        fault_dom_o  <= loss_dom;
                        fault_code_o <= FC_PG_LOSS;
                    end else if (dn_req_i) begin
                        state          <= S_DN_WAIT;
                        idx            <= LAST_IDX;
                        cnt            <= '0;
                        en_o[LAST_IDX] <= 1'b0;
                        busy_o         <= 1'b1;
                        all_on_o       <= 1'b0;
                    end
                end

                S_DN_WAIT: begin
                    if (!pg_idx) begin
                        state <= S_DN_SETTLE;
                        cnt   <= '0;
                    end else if (cnt >= TIMEOUT_C) begin
                        state        <= S_FAULT;
                        en_o         <= '0;
                        busy_o       <= 1'b0;
                        fault_o      <= 1'b1;
                        fault_dom_o  <= idx;
                        fault_code_o <= FC_DN_TIMEOUT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_DN_SETTLE: begin
                    if (cnt >= SETTLE_C) begin
                        cnt <= '0;
                        if (idx == '0) begin
                            state  <= S_OFF;
                            busy_o <= 1'b0;
                        end else begin
                            state         <= S_DN_WAIT;
                            idx           <= idx_prv;
                            en_o[idx_prv] <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_FAULT: begin
                    en_o <= '0;
                    if (clr_fault_i) begin
                        state        <= S_OFF;
                        idx          <= '0;
                        cnt          <= '0;
                        fault_o      <= 1'b0;
                        fault_dom_o  <= '0;
                        fault_code_o <= FC_NONE;
                    end
                end

                default: state <= S_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_riio_supply_seq.sv
// Scoreboard bench for riio_supply_seq: expected en_o steps are queued by the
// stimulus and popped by a monitor on every en_o change.
module tb_riio_supply_seq;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam int ST = 5;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_req_i = 1'b0;
    logic          dn_req_i = 1'b0;
    logic          clr_fault_i = 1'b0;
    logic [N-1:0]  pg_i = '0;
    logic [N-1:0]  en_o;
    logic          all_on_o;
    logic          busy_o;
    logic          fault_o;
    logic [DW-1:0] fault_dom_o;
    logic [1:0]    fault_code_o;

    logic [N-1:0]  pg_force0 = '0;
    logic [N-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_pass = 0;

    riio_supply_seq #(.N_DOM(N), .TIMEOUT_CYC(TO), .SETTLE_CYC(ST)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_req_i     (up_req_i),
        .dn_req_i     (dn_req_i),
        .clr_fault_i  (clr_fault_i),
        .pg_i         (pg_i),
        .en_o         (en_o),
        .all_on_o     (all_on_o),
        .busy_o       (busy_o),
        .fault_o      (fault_o),
        .fault_dom_o  (fault_dom_o),
        .fault_code_o (fault_code_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Supply model: pg follows en with a 3-cycle lag, minus any forced-low domains.
    initial begin
        logic [N-1:0] d1 = '0, d2 = '0, d3 = '0;
        forever begin
            @(posedge clk);
            #1;
            d3   = d2;
            d2   = d1;
            d1   = en_o;
            pg_i = d3 & ~pg_force0;
        end
    end

    // Monitor: every en_o change must match the next queued expectation.
    initial begin
        logic [N-1:0] prev = '0;
        forever begin
            @(negedge clk);
            if (en_o !== prev) begin
                if (exp_q.size() == 0) check("en_unexpected_change", 32'(en_o), 32'(prev));
                else check("en_step", 32'(en_o), 32'(exp_q.pop_front()));
                prev = en_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic up, input logic dn, input logic clr);
        @(negedge clk);
        up_req_i    = up;
        dn_req_i    = dn;
        clr_fault_i = clr;
        @(negedge clk);
        up_req_i    = 1'b0;
        dn_req_i    = 1'b0;
        clr_fault_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 = all_on_o high, 1 = busy_o low, 2 = fault_o high
    task automatic wait_for(input int which, input int budget, input string name);
        bit met = 1'b0;
        for (int c = 0; c < budget && !met; c++) begin
            @(negedge clk);
            case (which)
                0:       met = all_on_o;
                1:       met = !busy_o;
                default: met = fault_o;
            endcase
        end
        check(name, 32'(met), 32'd1);
    endtask

    task automatic power_up(input string name);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b1111);
        pulse(1'b1, 1'b0, 1'b0);
        wait_for(0, 300, name);
        check({name, "_busy"}, 32'(busy_o), 32'd0);
        check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic power_down(input string name);
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        pulse(1'b0, 1'b1, 1'b0);
        wait_for(1, 300, name);
        check({name, "_all_on"}, 32'(all_on_o), 32'd0);
        check({name, "_fault"}, 32'(fault_o), 32'd0);
        check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;

        // Reset state
        idle(3);
        rst = 1'b0;
        idle(1);
        check("rst_en", 32'(en_o), 32'd0);
        check("rst_all_on", 32'(all_on_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_fault_dom", 32'(fault_dom_o), 32'd0);
        check("rst_fault_code", 32'(fault_code_o), 32'd0);

        // Nominal up, ignored up_req in ON, nominal down
        power_up("nominal_up");
        pulse(1'b1, 1'b0, 1'b0);
        idle(10);
        check("up_in_on_all_on", 32'(all_on_o), 32'd1);
        check("up_in_on_en", 32'(en_o), 32'hF);
        power_down("nominal_down");

        // Simultaneous up+dn in OFF, and dn alone in OFF: no-ops
        pulse(1'b1, 1'b1, 1'b0);
        idle(10);
        check("up_dn_off_busy", 32'(busy_o), 32'd0);
        check("up_dn_off_en", 32'(en_o), 32'd0);
        pulse(1'b0, 1'b1, 1'b0);
        idle(10);
        check("dn_off_en", 32'(en_o), 32'd0);

        // Up timeout on domain 2
        pg_force0 = 4'b0100;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0000);
        pulse(1'b1, 1'b0, 1'b0);
        cyc = 0;
        while (!en_o[2] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("up_to_en2_rise", 32'(en_o[2]), 32'd1);
        cyc = 0;
        while (en_o != '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("up_to_latency", 32'(cyc), 32'(TO + 1));
        check("up_to_fault", 32'(fault_o), 32'd1);
        check("up_to_dom", 32'(fault_dom_o), 32'd2);
        check("up_to_code", 32'(fault_code_o), 32'd1);
        check("up_to_busy", 32'(busy_o), 32'd0);
        pg_force0 = '0;
        pulse(1'b0, 1'b0, 1'b1);
        check("clr_fault", 32'(fault_o), 32'd0);
        check("clr_code", 32'(fault_code_o), 32'd0);
        check("clr_dom", 32'(fault_dom_o), 32'd0);
        idle(10);

        // PG loss in ON: domain 1 drops for one cycle
        power_up("pgloss_up");
        exp_q.push_back(4'b0000);
        @(negedge clk);
        pg_force0 = 4'b0010;
        @(negedge clk);
        pg_force0 = '0;
        idle(2);
        check("pgloss_not_yet", 32'(fault_o), 32'd0);
        idle(1);
        check("pgloss_fault", 32'(fault_o), 32'd1);
        check("pgloss_code", 32'(fault_code_o), 32'd3);
        check("pgloss_dom", 32'(fault_dom_o), 32'd1);
        check("pgloss_en", 32'(en_o), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        idle(10);
        check("fault_ignores_up", 32'(fault_o), 32'd1);
        check("fault_ignores_up_code", 32'(fault_code_o), 32'd3);
        pulse(1'b0, 1'b0, 1'b1);
        idle(10);
        power_up("restart_up");
        power_down("restart_down");

        // Abort during UP_WAIT on domain 2
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0111);
        pulse(1'b1, 1'b0, 1'b0);
        cyc = 0;
        while (!en_o[2] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_en2_rise", 32'(en_o), 32'h7);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        pulse(1'b0, 1'b1, 1'b0);
        check("abort_en2_fall", 32'(en_o), 32'h3);
        wait_for(1, 300, "abort_done");
        check("abort_en", 32'(en_o), 32'd0);
        check("abort_fault", 32'(fault_o), 32'd0);
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset while busy
        exp_q.push_back(4'b0001);
        pulse(1'b1, 1'b0, 1'b0);
        check("rst_busy_pre", 32'(busy_o), 32'd1);
        exp_q.push_back(4'b0000);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_en", 32'(en_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_all_on", 32'(all_on_o), 32'd0);
        check("rst_mid_fault", 32'(fault_o), 32'd0);
        rst = 1'b0;
        idle(10);
        check("rst_mid_stays_off", 32'(en_o), 32'd0);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
